// File: rtl/key_debounce_arbiter.sv
// Multi-key debouncer: one shared stability timer, handed out round-robin to keys whose
// synchronised level disagrees with their debounced output.
module key_debounce_arbiter #(
   parameter int unsigned       N_KEYS   = 4,
   parameter int unsigned       IDX_BITS = 2,
   parameter int unsigned       NBITS    = 24,
   parameter logic [NBITS-1:0]  NUMBER   = 24'd10_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_KEYS-1:0]   key_i,
   output logic [N_KEYS-1:0]   key_o,
   output logic [N_KEYS-1:0]   press_o,
   output logic [N_KEYS-1:0]   release_o,
   output logic                busy_o,
   output logic [IDX_BITS-1:0] grant_o
);

   typedef enum logic [1:0] {StIdle, StCount, StCommit} state_e;

   state_e              state_q, state_d;
   logic [N_KEYS-1:0]   sync1_q, sync2_q;
   logic [N_KEYS-1:0]   key_q, key_d;
   logic [N_KEYS-1:0]   press_q, press_d;
   logic [N_KEYS-1:0]   release_q, release_d;
   logic [IDX_BITS-1:0] ptr_q, ptr_d;
   logic [IDX_BITS-1:0] grant_q, grant_d;
   logic                tgt_q, tgt_d;
   logic [NBITS-1:0]    count_q, count_d;

   logic [N_KEYS-1:0]   pending;
   logic                found;
   logic [IDX_BITS-1:0] pick;
   logic [IDX_BITS-1:0] cand;

   function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] i);
      if (32'(i) == N_KEYS - 1) return '0;
      else return i + 1'b1;
   endfunction

   // Level-based: a change stays pending until it is committed or the key reverts.
   assign pending = sync2_q ^ key_q;

   // First pending key at or after ptr, wrapping within N_KEYS.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned off = 0; off < N_KEYS; off++) begin
         cand = IDX_BITS'((32'(ptr_q) + off) % N_KEYS);
         if (!found && pending[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      tgt_d     = tgt_q;
      count_d   = count_q;
      key_d     = key_q;
      press_d   = '0;
      release_d = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = pick;
               tgt_d   = sync2_q[pick];
               count_d = '0;
               state_d = StCount;
            end
         end
         StCount: begin
            if (sync2_q[grant_q] != tgt_q) begin
               ptr_d   = next_idx(grant_q);
               state_d = StIdle;
            end else if (count_q == NUMBER) begin
               state_d = StCommit;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StCommit: begin
            key_d[grant_q]     = tgt_q;
            press_d[grant_q]   = tgt_q;
            release_d[grant_q] = ~tgt_q;
            ptr_d              = next_idx(grant_q);
            state_d            = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sync1_q   <= '0;
         sync2_q   <= '0;
         key_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
         ptr_q     <= '0;
         grant_q   <= '0;
         tgt_q     <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= key_i;
         sync2_q   <= sync1_q;
         key_q     <= key_d;
         press_q   <= press_d;
         release_q <= release_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         tgt_q     <= tgt_d;
         count_q   <= count_d;
      end
   end

   assign key_o     = key_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign busy_o    = (state_q != StIdle);
   assign grant_o   = grant_q;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Directed bench for key_debounce_arbiter with NUMBER=8: commit lands 12 edges after the
// change is first sampled.
module tb_key_debounce_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_i;
   logic [3:0] key_o;
   logic [3:0] press_o;
   logic [3:0] release_o;
   logic       busy_o;
   logic [1:0] grant_o;

   int tests_run;
   int fails;

   key_debounce_arbiter #(
      .N_KEYS   (4),
      .IDX_BITS (2),
      .NBITS    (24),
      .NUMBER   (24'd8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (key_i),
      .key_o     (key_o),
      .press_o   (press_o),
      .release_o (release_o),
      .busy_o    (busy_o),
      .grant_o   (grant_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int bad;
      rst_n = 1'b0;
      key_i = 4'b0000;
      #23;
      tests_run++;
      if ({key_o, press_o, release_o, busy_o, grant_o} !== 15'd0) begin
         fails++;
         $display("FAIL reset_outputs: got key=%b press=%b rel=%b busy=%b grant=%0d, want all 0",
                  key_o, press_o, release_o, busy_o, grant_o);
      end
      tick(1);
      rst_n = 1'b1;
      bad = 0;
      for (int t = 0; t < 30; t++) begin
         tick(1);
         if (busy_o !== 1'b0 || key_o !== 4'b0 || press_o !== 4'b0 || release_o !== 4'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_quiet: %0d cycles with activity, want 0", bad);
      end
   endtask

   task automatic test_press_release;
      key_i = 4'b0010;
      tick(5);
      tests_run++;
      if (busy_o !== 1'b1 || grant_o !== 2'd1) begin
         fails++;
         $display("FAIL press_counting: busy=%b grant=%0d, want 1/1", busy_o, grant_o);
      end
      tick(7);
      tests_run++;
      if (key_o !== 4'b0000 || press_o !== 4'b0000) begin
         fails++;
         $display("FAIL press_early: key=%b press=%b, want 0000/0000", key_o, press_o);
      end
      tick(1);
      tests_run++;
      if (key_o !== 4'b0010 || press_o !== 4'b0010 || release_o !== 4'b0 || grant_o !== 2'd1) begin
         fails++;
         $display("FAIL press_commit: key=%b press=%b rel=%b grant=%0d, want 0010/0010/0000/1",
                  key_o, press_o, release_o, grant_o);
      end
      tick(1);
      tests_run++;
      if (press_o !== 4'b0000 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL press_one_cycle: press=%b busy=%b, want 0000/0", press_o, busy_o);
      end
      key_i = 4'b0000;
      tick(12);
      tests_run++;
      if (key_o !== 4'b0010 || release_o !== 4'b0000) begin
         fails++;
         $display("FAIL release_early: key=%b rel=%b, want 0010/0000", key_o, release_o);
      end
      tick(1);
      tests_run++;
      if (key_o !== 4'b0000 || release_o !== 4'b0010 || press_o !== 4'b0000) begin
         fails++;
         $display("FAIL release_commit: key=%b rel=%b press=%b, want 0000/0010/0000",
                  key_o, release_o, press_o);
      end
      tick(1);
      tests_run++;
      if (release_o !== 4'b0000) begin
         fails++;
         $display("FAIL release_one_cycle: rel=%b, want 0000", release_o);
      end
   endtask

   task automatic test_bounce;
      int n_press;
      int at;
      logic busy_t2;
      logic busy_t3;
      n_press = 0;
      at      = -1;
      busy_t2 = 1'b0;
      busy_t3 = 1'b1;
      for (int t = 0; t < 30; t++) begin
         key_i[2] = (t == 0 || t >= 4);
         tick(1);
         if (t == 2) busy_t2 = busy_o;
         if (t == 3) busy_t3 = busy_o;
         if (press_o[2]) begin
            n_press++;
            at = t;
         end
      end
      tests_run++;
      if (busy_t2 !== 1'b1 || busy_t3 !== 1'b0) begin
         fails++;
         $display("FAIL bounce_abort: busy at t2=%b t3=%b, want 1/0", busy_t2, busy_t3);
      end
      tests_run++;
      if (n_press != 1 || at != 16) begin
         fails++;
         $display("FAIL bounce_press: %0d pulses at t=%0d, want 1 at t=16", n_press, at);
      end
      tests_run++;
      if (key_o !== 4'b0100) begin
         fails++;
         $display("FAIL bounce_level: key=%b, want 0100", key_o);
      end
   endtask

   task automatic test_simultaneous;
      int at0;
      int at3;
      int both;
      logic [1:0] grant_t14;
      at0  = -1;
      at3  = -1;
      both = 0;
      grant_t14 = 2'd0;
      rst_n = 1'b0;
      key_i = 4'b0000;
      #3;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      key_i = 4'b1001;
      for (int t = 1; t <= 40; t++) begin
         tick(1);
         if (t == 14) grant_t14 = grant_o;
         if (press_o == 4'b1001) both++;
         if (press_o[0]) at0 = t;
         if (press_o[3]) at3 = t;
      end
      tests_run++;
      if (at0 != 13 || at3 != 24) begin
         fails++;
         $display("FAIL rr_order: key0 at %0d key3 at %0d, want 13/24", at0, at3);
      end
      tests_run++;
      if (grant_t14 !== 2'd3) begin
         fails++;
         $display("FAIL rr_grant: grant after key0 commit=%0d, want 3", grant_t14);
      end
      tests_run++;
      if (both != 0 || key_o !== 4'b1001) begin
         fails++;
         $display("FAIL rr_separate: together=%0d key=%b, want 0/1001", both, key_o);
      end
   endtask

   task automatic test_revert;
      int n2;
      int at2;
      int ev1;
      n2  = 0;
      at2 = -1;
      ev1 = 0;
      for (int t = 0; t < 30; t++) begin
         key_i = 4'b1101;
         if (t >= 4 && t < 7) key_i[1] = 1'b1;
         tick(1);
         if (press_o[2]) begin
            n2++;
            at2 = t;
         end
         if (press_o[1] || release_o[1]) ev1++;
      end
      tests_run++;
      if (n2 != 1 || at2 != 12) begin
         fails++;
         $display("FAIL revert_key2: %0d pulses at t=%0d, want 1 at t=12", n2, at2);
      end
      tests_run++;
      if (ev1 != 0 || key_o !== 4'b1101) begin
         fails++;
         $display("FAIL revert_key1: key1 events=%0d key=%b, want 0/1101", ev1, key_o);
      end
      tests_run++;
      if (busy_o !== 1'b0 || grant_o !== 2'd2) begin
         fails++;
         $display("FAIL revert_idle: busy=%b grant=%0d, want 0/2", busy_o, grant_o);
      end
   endtask

   task automatic test_reset_mid;
      int at0;
      int at1;
      int early;
      at0   = -1;
      at1   = -1;
      early = 0;
      key_i = 4'b1111;
      tick(6);
      tests_run++;
      if (busy_o !== 1'b1 || grant_o !== 2'd1) begin
         fails++;
         $display("FAIL mid_counting: busy=%b grant=%0d, want 1/1", busy_o, grant_o);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({key_o, press_o, release_o, busy_o, grant_o} !== 15'd0) begin
         fails++;
         $display("FAIL mid_abort: key=%b press=%b rel=%b busy=%b grant=%0d, want all 0",
                  key_o, press_o, release_o, busy_o, grant_o);
      end
      tick(2);
      rst_n = 1'b1;
      for (int t = 1; t <= 50; t++) begin
         tick(1);
         if (t < 13 && (key_o !== 4'b0 || press_o !== 4'b0)) early++;
         if (press_o[0]) at0 = t;
         if (press_o[1]) at1 = t;
      end
      tests_run++;
      if (early != 0 || at0 != 13 || at1 != 24) begin
         fails++;
         $display("FAIL mid_redebounce: early=%0d key0 at %0d key1 at %0d, want 0/13/24",
                  early, at0, at1);
      end
      tests_run++;
      if (key_o !== 4'b1111) begin
         fails++;
         $display("FAIL mid_final: key=%b, want 1111", key_o);
      end
   endtask

   initial begin
      tests_run = 0;
      fails     = 0;
      rst_n     = 1'b0;
      key_i     = 4'b0000;
      test_reset;
      test_press_release;
      test_bounce;
      test_simultaneous;
      test_revert;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/key_debounce_arbiter.md
Name: key_debounce_arbiter

Overview:
- Debounces N push-button inputs with one shared stability timer instead of one counter per key.
- Every key is synchronised continuously. A round-robin arbiter grants the single timer to one key at a time, and only for keys whose synchronised level differs from their debounced output.
- On a confirmed change it updates the debounced level and emits one-cycle press/release pulses for the board-level control logic (single-step, reset-request and display-select buttons).

Parameters:
- N_KEYS, 4, number of key inputs.
- IDX_BITS, 2, width of the key index; 2**IDX_BITS >= N_KEYS.
- NUMBER, 24'd10_000_000, number of stable clock cycles required before a change is accepted.
- NBITS, 24, timer width; must hold NUMBER.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- key_i  input  N_KEYS  raw, asynchronous button levels.
- key_o  output  N_KEYS  debounced levels.
- press_o  output  N_KEYS  one-cycle pulse when key_o[i] goes 0->1.
- release_o  output  N_KEYS  one-cycle pulse when key_o[i] goes 1->0.
- busy_o  output  1  timer currently owned by a key (state COUNT or COMMIT).
- grant_o  output  IDX_BITS  index of the current or most recent timer owner.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - key_o, press_o, release_o = 0; busy_o = 0; grant_o = 0.
  - Synchroniser flops = 0; round-robin pointer ptr = 0; count = 0; target tgt = 0; state = IDLE.
- Reset asserted mid-operation aborts immediately, with no pulse.
- Synchroniser: two flops per key, giving s[i]. pending[i] = (s[i] != key_o[i]). Pending is level-based, so a waiting change is never lost.
- press_o and release_o are registered and default to 0 every cycle; each is high for exactly one cycle per event.
- IDLE:
  - If any pending bit is set, pick the first pending index scanning from ptr upward with wrap-around.
  - Latch it to grant_o, set tgt = s[idx], count = 0, go to COUNT.
  - If nothing is pending, stay in IDLE.
- COUNT (checked in this priority order):
  - If s[grant_o] != tgt: bounce. Go to IDLE, ptr = grant_o+1 (mod N_KEYS), no output change.
  - Else if count == NUMBER: go to COMMIT.
  - Else count = count+1.
- COMMIT:
  - key_o[grant_o] = tgt.
  - press_o[grant_o] = tgt; release_o[grant_o] = ~tgt.
  - ptr = grant_o+1 (mod N_KEYS); go to IDLE.
- Latency: a key_i change first sampled at edge k, held stable, updates key_o and pulses at edge k+NUMBER+4, provided the timer is free.
- NUMBER=0 is legal: COUNT proceeds to COMMIT on the next edge.
- Fairness:
  - Simultaneous pending keys are served in round-robin order.
  - A pending key waits at most N_KEYS-1 grants.
  - A key that reverts while waiting clears its pending bit and produces no event.
  - Changes on non-granted keys during COUNT do not disturb the timer.
- Indices >= N_KEYS are never granted; a wrapped ptr past N_KEYS-1 restarts at 0.
- count never exceeds NUMBER; no overflow.

Test Plan (NUMBER=8, N_KEYS=4):
- Reset, hold key_i=0 -> key_o=0, no pulses, busy_o=0 indefinitely.
- key_i[1] 0->1 at edge k, held -> key_o[1]=1 and press_o=4'b0010 for one cycle at edge k+12; grant_o=1. Release 1->0 -> release_o=4'b0010 likewise.
- key_i[2] toggles 1 cycle high, 3 cycles low, then stays high -> the bounce returns the FSM to IDLE with no pulse. Exactly one press_o[2], 12 edges after the final rising level is first sampled.
- key_i[0] and key_i[3] rise on the same edge, ptr=0 -> key 0 committed first. Key 3 is granted the cycle after key 0's COMMIT and commits after a further NUMBER+3 edges. Two pulses, never together.
- Key 1 pending while key 2 counting, then key 1 returns to 0 before its grant -> no event for key 1; key 2 commits normally.
- rst_n asserted during COUNT -> all outputs 0 immediately; after release, a still-held key re-debounces from scratch with full latency.
